// File: rtl/rf_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around a 2-port register file (RF_2F).
// A 2-entry skid buffer absorbs the 1-cycle RF read latency to keep 1 word/cycle.
module rf_fifo_ctrl #(
    parameter int wordWd = 12,
    parameter int DWd    = 32,
    parameter int AWd    = $clog2(wordWd),
    parameter int CWd    = $clog2(wordWd + 3)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [DWd-1:0] i_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [DWd-1:0] o_data,
    output logic [CWd-1:0] o_count,
    output logic           o_rf_read,
    output logic [AWd-1:0] o_rf_raddr,
    input  logic [DWd-1:0] i_rf_rdata,
    output logic           o_rf_write,
    output logic [AWd-1:0] o_rf_waddr,
    output logic [DWd-1:0] o_rf_wdata
);

    localparam logic [AWd-1:0] LAST_ADDR = AWd'(wordWd - 1);
    localparam logic [CWd-1:0] DEPTH     = CWd'(wordWd);

    logic [AWd-1:0] wptr_q, wptr_d;
    logic [AWd-1:0] rptr_q, rptr_d;
    logic [CWd-1:0] rf_count_q, rf_count_d;
    logic           inflight_q, inflight_d;
    logic [1:0]     skid_cnt_q, skid_cnt_d;
    logic [DWd-1:0] skid0_q, skid0_d;
    logic [DWd-1:0] skid1_q, skid1_d;
    logic           ready_q, ready_d;

    logic push;
    logic pop;
    logic rd;

    // Clear wins over every other action in its cycle.
    assign push = i_valid & ready_q & ~i_clear;
    assign pop  = (skid_cnt_q != 2'd0) & i_ready & ~i_clear;
    // Issue a read only if the skid will have room when the data lands.
    assign rd   = (rf_count_q != '0) & ~i_clear &
                  (({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rf_count_d = rf_count_q;
        inflight_d = rd;
        skid_cnt_d = skid_cnt_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        ready_d    = ready_q;

        if (push) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
        end
        if (rd) begin
            rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + 1'b1;
        end
        rf_count_d = rf_count_q + CWd'(push) - CWd'(rd);

        // Head only shifts when a second entry exists, so o_data holds when emptied.
        if (pop) begin
            if (skid_cnt_q == 2'd2) begin
                skid0_d = skid1_q;
            end
            skid_cnt_d = skid_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (skid_cnt_d == 2'd0) begin
                skid0_d = i_rf_rdata;
            end else begin
                skid1_d = i_rf_rdata;
            end
            skid_cnt_d = skid_cnt_d + 2'd1;
        end

        ready_d = (rf_count_d < DEPTH);

        if (i_clear) begin
            wptr_d     = '0;
            rptr_d     = '0;
            rf_count_d = '0;
            inflight_d = 1'b0;
            skid_cnt_d = '0;
            skid0_d    = '0;
            skid1_d    = '0;
            ready_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rf_count_q <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= '0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rf_count_q <= rf_count_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            ready_q    <= ready_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = (skid_cnt_q != 2'd0);
    assign o_data     = skid0_q;
    assign o_count    = rf_count_q + CWd'(inflight_q) + CWd'(skid_cnt_q);
    assign o_rf_read  = rd;
    assign o_rf_raddr = rptr_q;
    assign o_rf_write = push;
    assign o_rf_waddr = wptr_q;
    assign o_rf_wdata = i_data;

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Scoreboard bench for rf_fifo_ctrl with a behavioural 1-cycle-latency register file.
module tb_rf_fifo_ctrl;

    localparam int WW = 12;
    localparam int DW = 32;
    localparam int AW = $clog2(WW);
    localparam int CW = $clog2(WW + 3);

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          valid;
    logic          o_ready;
    logic [DW-1:0] data;
    logic          o_valid;
    logic          ready_in;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;
    logic          o_rf_read;
    logic [AW-1:0] o_rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          o_rf_write;
    logic [AW-1:0] o_rf_waddr;
    logic [DW-1:0] o_rf_wdata;

    logic [DW-1:0] rf_mem [WW];
    logic [DW-1:0] sbq [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_pop    = 0;

    rf_fifo_ctrl #(.wordWd(WW), .DWd(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_valid(valid), .o_ready(o_ready), .i_data(data),
        .o_valid(o_valid), .i_ready(ready_in), .o_data(o_data),
        .o_count(o_count),
        .o_rf_read(o_rf_read), .o_rf_raddr(o_rf_raddr), .i_rf_rdata(rf_rdata),
        .o_rf_write(o_rf_write), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rf_write) rf_mem[o_rf_waddr] <= o_rf_wdata;
        if (o_rf_read)  rf_rdata <= rf_mem[o_rf_raddr];
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted input, compare on accepted output.
    always @(negedge clk) begin
        if (!rst) begin
            if (clear) begin
                check_eq("clr_nowrite", 64'(o_rf_write), 64'd0);
                check_eq("clr_noread", 64'(o_rf_read), 64'd0);
                sbq.delete();
            end else begin
                check_eq("wr_strobe", 64'(o_rf_write), 64'(valid && o_ready));
                if (o_rf_write) check_eq("waddr_range", 64'(o_rf_waddr < AW'(WW)), 64'd1);
                if (o_rf_read)  check_eq("raddr_range", 64'(o_rf_raddr < AW'(WW)), 64'd1);
                if (o_rf_write && o_rf_read)
                    check_eq("same_addr", 64'(o_rf_waddr != o_rf_raddr), 64'd1);
                if (valid && o_ready) sbq.push_back(data);
                if (o_valid && ready_in) begin
                    n_pop++;
                    if (sbq.size() == 0) check_eq("sb_underflow", 64'd0, 64'd1);
                    else check_eq("sb_data", 64'(o_data), 64'(sbq.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cyc;
        int base;
        rst = 1'b1; clear = 1'b0; valid = 1'b0; ready_in = 1'b0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ready", 64'(o_ready), 64'd0);
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_data", 64'(o_data), 64'd0);
        check_eq("rst_count", 64'(o_count), 64'd0);
        check_eq("rst_read", 64'(o_rf_read), 64'd0);
        check_eq("rst_write", 64'(o_rf_write), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_ready_low", 64'(o_ready), 64'd0);
        tick();
        @(negedge clk);
        check_eq("rel_ready_high", 64'(o_ready), 64'd1);

        // Single word latency
        tick();
        valid = 1'b1; data = 32'hA5A5_0001; ready_in = 1'b1;
        @(negedge clk);
        check_eq("one_write", 64'(o_rf_write), 64'd1);
        check_eq("one_waddr", 64'(o_rf_waddr), 64'd0);
        tick();
        valid = 1'b0;
        @(negedge clk);
        check_eq("one_read", 64'(o_rf_read), 64'd1);
        check_eq("one_raddr", 64'(o_rf_raddr), 64'd0);
        check_eq("one_valid_n1", 64'(o_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("one_valid_n2", 64'(o_valid), 64'd0);
        tick();
        @(negedge clk);
        check_eq("one_valid_n3", 64'(o_valid), 64'd1);
        check_eq("one_data", 64'(o_data), 64'hA5A5_0001);
        check_eq("one_count", 64'(o_count), 64'd1);
        tick();
        @(negedge clk);
        check_eq("one_count_after", 64'(o_count), 64'd0);
        check_eq("one_valid_after", 64'(o_valid), 64'd0);

        // Fill to full with downstream stalled
        tick();
        ready_in = 1'b0; valid = 1'b1; data = 32'd0; acc = 0; cyc = 0;
        while (acc < 14 && cyc < 100) begin
            @(negedge clk);
            if (o_ready) acc++;
            tick();
            data = DW'(acc);
            cyc++;
        end
        check_eq("fill_timeout", 64'(cyc < 100), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check_eq("full_ready", 64'(o_ready), 64'd0);
            check_eq("full_nowrite", 64'(o_rf_write), 64'd0);
            tick();
        end
        check_eq("full_accepted", 64'(acc), 64'd14);
        check_eq("full_count", 64'(o_count), 64'd14);
        valid = 1'b0;

        // Drain with no bubble
        ready_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check_eq("drain_valid", 64'(o_valid), 64'd1);
            tick();
        end
        @(negedge clk);
        check_eq("drain_empty", 64'(o_valid), 64'd0);
        check_eq("drain_count", 64'(o_count), 64'd0);
        check_eq("drain_sb", 64'(sbq.size()), 64'd0);

        // Continuous streaming
        tick();
        valid = 1'b1; ready_in = 1'b1; data = 32'd1000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_eq("stream_ready", 64'(o_ready), 64'd1);
            if (c < 3) begin
                check_eq("stream_lat", 64'(o_valid), 64'd0);
            end else begin
                check_eq("stream_valid", 64'(o_valid), 64'd1);
                check_eq("stream_count", 64'(o_count), 64'd3);
            end
            tick();
            data = 32'd1000 + DW'(c + 1);
        end
        valid = 1'b0;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 50) begin
            @(negedge clk);
            tick();
            cyc++;
        end
        check_eq("stream_drain", 64'(sbq.size()), 64'd0);

        // Random stalls
        acc = 0; cyc = 0; base = n_pop;
        while ((acc < 1000 || sbq.size() != 0) && cyc < 20000) begin
            valid    = (acc < 1000) && ($urandom_range(0, 3) != 0);
            data     = $urandom;
            ready_in = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (valid && o_ready) acc++;
            tick();
            cyc++;
        end
        valid = 1'b0;
        check_eq("rand_timeout", 64'(cyc < 20000), 64'd1);
        check_eq("rand_pops", 64'(n_pop - base), 64'd1000);
        check_eq("rand_sb", 64'(sbq.size()), 64'd0);

        // Clear with contents held and a read in flight
        valid = 1'b1; ready_in = 1'b0; acc = 0; cyc = 0;
        while (acc < 6 && cyc < 50) begin
            data = 32'h0C00_0000 + DW'(acc);
            @(negedge clk);
            if (o_ready) acc++;
            tick();
            cyc++;
        end
        valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("clr_pre_count", 64'(o_count), 64'd6);
        tick();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0; clear = 1'b1; valid = 1'b1; data = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("clr_held_count", 64'(o_count), 64'd5);
        check_eq("clr_inflight", 64'(o_rf_write), 64'd0);
        tick();
        clear = 1'b0; valid = 1'b0;
        @(negedge clk);
        check_eq("clr_valid", 64'(o_valid), 64'd0);
        check_eq("clr_count", 64'(o_count), 64'd0);
        check_eq("clr_ready_low", 64'(o_ready), 64'd0);
        tick();
        @(negedge clk);
        check_eq("clr_ready_high", 64'(o_ready), 64'd1);
        check_eq("clr_stale", 64'(o_valid), 64'd0);
        tick();
        valid = 1'b1; data = 32'h5555_0001;
        @(negedge clk);
        check_eq("post_write", 64'(o_rf_write), 64'd1);
        check_eq("post_waddr", 64'(o_rf_waddr), 64'd0);
        tick();
        valid = 1'b0; ready_in = 1'b1; cyc = 0;
        while (!o_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        @(negedge clk);
        check_eq("post_valid", 64'(o_valid), 64'd1);
        check_eq("post_data", 64'(o_data), 64'h5555_0001);
        tick();
        @(negedge clk);
        check_eq("post_sb", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_fifo_ctrl.md
Name: rf_fifo_ctrl

Overview:
- Streaming FIFO controller that turns one RF_2F 2-port register file (wordWd x DWd) into a valid/ready FIFO.
- Upstream side accepts words from the producer and drives the RF write port. Downstream side issues RF reads and absorbs the 1-cycle RF read latency in a 2-entry output skid buffer.
- Sits directly in front of RF_2F inside each PE buffer. It is the only driver of RF_2F's i_read/i_write/i_raddr/i_waddr/i_wdata and the only consumer of o_rdata.

Parameters:
- wordWd, 12, RF depth in words; need not be a power of two (12 and 48 are used).
- DWd, 32, data width; one of 8/16/32/64.
- AWd, $clog2(wordWd), RF address width.
- CWd, $clog2(wordWd+3), width of o_count.

Ports:
- i_clk  input  1  clock; all logic on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous flush.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  upstream may push (registered).
- i_data  input  DWd  upstream word.
- o_valid  output  1  downstream word valid.
- i_ready  input  1  downstream accepts.
- o_data  output  DWd  head word.
- o_count  output  CWd  total words held (RF + in-flight + skid).
- o_rf_read  output  1  to RF_2F i_read.
- o_rf_raddr  output  AWd  to RF_2F i_raddr.
- i_rf_rdata  input  DWd  from RF_2F o_rdata, valid the cycle after o_rf_read.
- o_rf_write  output  1  to RF_2F i_write.
- o_rf_waddr  output  AWd  to RF_2F i_waddr.
- o_rf_wdata  output  DWd  to RF_2F i_wdata.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - wptr, rptr, rf_count, inflight, skid count/entries all 0.
  - o_ready=0, o_valid=0, o_data=0, o_count=0, o_rf_read=0, o_rf_write=0.
  - o_ready rises at the first rising edge after release.
  - Reset asserted mid-operation discards all contents immediately.
- Push: push = i_valid & o_ready.
  - o_rf_write=push, o_rf_waddr=wptr, o_rf_wdata=i_data (combinational).
  - On push, wptr increments; at wordWd-1 it wraps to 0 (explicit compare, not modulo 2^AWd).
- o_ready is registered: o_ready <= (rf_count_next < wordWd). There is no combinational path from i_ready or reads to o_ready.
- Pop: pop = o_valid & i_ready. o_data is the skid head (registered). The skid buffer shifts on pop.
- Read issue: rd = (rf_count>0) & (skid_cnt + inflight - pop < 2).
  - o_rf_read=rd, o_rf_raddr=rptr.
  - On rd: rptr wraps the same way as wptr, rf_count decrements, and inflight <= 1 for the next cycle.
  - Sustains 1 word/cycle when i_ready is held high.
- Landing: when inflight=1, i_rf_rdata is written into the skid at the tail position after any same-cycle pop. o_valid is asserted the following cycle.
- rf_count_next = rf_count + push - rd, so simultaneous push and read leave it unchanged.
- Latency: push in cycle N into an empty FIFO → o_rf_read in N+1 → rdata in N+2 → o_valid=1 in N+3.
- Same-address hazard cannot occur:
  - A push only happens when rf_count < wordWd, so wptr never equals an occupied rptr slot.
  - The controller never reads and writes the same RF address in one cycle.
- Full: rf_count==wordWd drives o_ready=0 from the next cycle. The maximum o_count is wordWd+2.
- Empty: o_valid=0 while skid_cnt=0, and o_data holds its last value.
- i_clear has priority over push, pop, read and landing in the same cycle:
  - Pointers, counts, inflight and skid are zeroed at the edge. o_valid=0 and o_count=0 the next cycle.
  - o_rf_read and o_rf_write are forced 0 in the clear cycle, so a push offered in that cycle is dropped.
  - o_ready is 0 for the cycle after clear, then 1.
  - An in-flight rdata landing in the cycle after clear is discarded.
- o_count = rf_count + inflight + skid_cnt (registered components).

Test Plan:
- Reset release, push 0xA5A5_0001 once with i_ready=1 → o_rf_write/o_rf_waddr=0 at cycle N, o_rf_read/o_rf_raddr=0 at N+1, o_valid=1 with o_data=0xA5A5_0001 at N+3, o_count 1→0 after pop.
- i_ready=0, push 0..13 continuously (wordWd=12) → 14 words accepted (12 RF + 2 skid, in-flight drained). o_ready=0 thereafter, o_count=14. No o_rf_write while o_ready=0.
- From full, set i_ready=1 → data 0..13 pops in order with no bubble. waddr/raddr wrap 11→0 and never reach 12.
- Continuous push and pop for 100 words with i_valid=i_ready=1 → after the first-word latency of 3, one output per cycle. Sequence matches, o_count is constant.
- Random i_valid/i_ready stalls over 1000 words → scoreboard matches in order, no drop or duplicate. At no cycle are o_rf_read and o_rf_write on the same address.
- With 5 words held and one in-flight, assert i_clear together with i_valid=1 → that push is dropped (no o_rf_write). Next cycle o_valid=0, o_count=0, o_ready=0, then o_ready=1. The stale landing is ignored, and a subsequent push uses address 0.
